// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: drives the datapath strobes that compute
// PC + C and conditionally load PC, beside the main control unit.
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int         CNT_W     = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             cond_d,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [1:0]       c2,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             zlow_out,
    output logic             pc_in,
    output logic             con_q,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_ADDR,
        S_ADD,
        S_WB,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       c2_q, c2_d;
    logic             con_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and datapath-facing registers; clear_n aborts any sequence.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            c2_q      <= 2'b00;
            con_q     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            c2_q      <= c2_d;
            con_q     <= con_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: advance one step per unstalled cycle, FIN ignores stall.
    always_comb begin
        state_d   = state_q;
        c2_d      = c2_q;
        con_d     = con_q;
        illegal_d = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ir[31:27] == BR_OPCODE) begin
                        state_d = S_EVAL;
                        c2_d    = ir[20:19];
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                if (!stall) begin
                    state_d = S_ADDR;
                    con_d   = cond_d;
                end
            end
            S_ADDR: begin
                if (!stall) state_d = S_ADD;
            end
            S_ADD: begin
                if (!stall) state_d = S_WB;
            end
            S_WB: begin
                if (!stall) begin
                    state_d = S_FIN;
                    if (con_q && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore strobes for the current step, suppressed while stalled.
    always_comb begin
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        pc_out   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_add  = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        pc_in    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        unique case (state_q)
            S_EVAL: begin
                gra    = ~stall;
                r_out  = ~stall;
                con_in = ~stall;
            end
            S_ADDR: begin
                pc_out = ~stall;
                y_in   = ~stall;
            end
            S_ADD: begin
                c_out   = ~stall;
                alu_add = ~stall;
                z_in    = ~stall;
            end
            S_WB: begin
                zlow_out = ~stall;
                pc_in    = ~stall & con_q;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign illegal     = illegal_q;
    assign c2          = c2_q;
    assign taken_count = cnt_q;

endmodule
